piece_mover: RTL and testbench
==============================

PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, meaning board width in cells.
REQ-002 SHALL have parameter BOARD_H, default 20, meaning board height in cells.
REQ-003 SHALL have parameter GRAVITY_DIV, default 25000000, meaning clock cycles per gravity step (0.5 s at 50 MHz).
REQ-004 SHALL have parameter SPAWN_X, default 4, meaning spawn column.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports btn_left, btn_right and btn_drop, each input, 1 bit: single-cycle move request pulses.
REQ-008 SHALL have ports occ_x (output, 4 bits) and occ_y (output, 5 bits): occupancy query coordinate.
REQ-009 SHALL have port occ_hit, input, 1 bit: the queried cell is occupied, returned combinationally in the same cycle.
REQ-010 SHALL have ports x_pos (output, 4 bits) and y_pos (output, 5 bits): the active piece cell.
REQ-011 SHALL have port piece_active, output, 1 bit: a piece is on the board.
REQ-012 SHALL have ports lock_valid (output, 1 bit) and lock_ready (input, 1 bit): the lock-write handshake to the board store.
REQ-013 SHALL have port game_over, output, 1 bit: sticky game-over flag.

Function
REQ-014 SHALL implement the states SPAWN, FALL, LOCK and GAMEOVER.
REQ-015 SPAWN SHALL drive occ=(SPAWN_X,0).
  - occ_hit=1: go to GAMEOVER.
  - otherwise: set x_pos=SPAWN_X, y_pos=0 and piece_active=1, then go to FALL.
REQ-016 SHALL have a gravity counter that counts 0..GRAVITY_DIV-1 only in FALL.
  - A tick occurs at GRAVITY_DIV-1, and the counter then wraps to 0.
  - The counter clears to 0 on entry to FALL.
REQ-017 In FALL, at most one action SHALL occur per cycle, in this priority: down (tick or btn_drop), then left, then right.
REQ-018 Down SHALL query (x,y+1).
  - If y_pos==BOARD_H-1 or occ_hit=1: go to LOCK with no move.
  - Otherwise: y_pos increments by 1.
REQ-019 Left SHALL query (x-1,y) and decrement x_pos only if x_pos>0 and occ_hit=0.
REQ-020 Right SHALL query (x+1,y) and increment x_pos only if x_pos<BOARD_W-1 and occ_hit=0.
REQ-021 If btn_left and btn_right are high together with no down request, SHALL make no move.
REQ-022 A move SHALL appear on x_pos/y_pos the cycle after the request. There is no request buffering, and button pulses outside FALL are dropped.
REQ-023 occ_x/occ_y SHALL be combinational from state, position and buttons. When no query is needed, they SHALL equal x_pos/y_pos.
REQ-024 LOCK SHALL assert lock_valid with x_pos/y_pos held stable until lock_ready=1.
  - In the handshake cycle (lock_valid and lock_ready both 1): next cycle lock_valid=0, piece_active=0, and the state goes to SPAWN.
REQ-025 GAMEOVER SHALL drive game_over=1, piece_active=0 and lock_valid=0, and SHALL remain there until rst.
REQ-026 Coordinate arithmetic SHALL never wrap. Boundary checks SHALL precede any increment or decrement.

Reset
REQ-027 With rst=1 at a clock edge, on that edge:
  - state=SPAWN;
  - x_pos=0, y_pos=0;
  - piece_active=0, lock_valid=0, game_over=0;
  - gravity counter=0.
REQ-028 Reset SHALL override any state, including LOCK mid-handshake and GAMEOVER.

Structure
REQ-029 A shared package/include (arcade_defs) SHALL hold BOARD_W, BOARD_H, the coordinate widths and the state encodings.
REQ-030 The gravity counter SHALL be a sub-module, gravity_timer, with inputs clk, rst and enable and a tick pulse output.

Verification (GRAVITY_DIV=4 unless stated)
REQ-031 Spawn: release rst, occ_hit=0 -> x=4, y=0, piece_active=1, game_over=0.
REQ-032 Lateral moves and wall: GRAVITY_DIV=1000, occ_hit=0, five btn_left pulses from x=4 -> x=3,2,1,0, then x stays 0; one btn_right -> x=1.
REQ-033 Gravity and floor lock:
  - Stimulus: no buttons, lock_ready=0.
  - Response: y increments every 4 cycles to 19; the next tick gives lock_valid=1 at (4,19), held for 3 cycles.
  - Then lock_ready=1 -> piece_active=0 next cycle, followed by a respawn at (4,0).
REQ-034 Stack collision: occ_hit=1 only when occ=(4,6), piece at y=5, btn_drop -> LOCK with y_pos=5 and lock_valid=1.
REQ-035 Game over: occ_hit=1 at (4,0) during SPAWN -> game_over=1 and piece_active=0, persisting 100 cycles until rst clears it.
REQ-036 Conflicts and mid-operation reset:
  - btn_left and btn_right together at x=4 -> x stays 4.
  - btn_drop and btn_left together -> only y changes.
  - rst during LOCK -> all outputs at reset values after the edge.

Source files
------------

// File: rtl/arcade_defs.sv
// Shared board geometry, coordinate widths and piece-mover state encoding
// for the arcade block-stacking game.
package arcade_defs;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int X_W     = 4;
    localparam int Y_W     = 5;

    typedef enum logic [1:0] {
        ST_SPAWN    = 2'd0,
        ST_FALL     = 2'd1,
        ST_LOCK     = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

endpackage

// File: rtl/gravity_timer.sv
// Free-running gravity divider: pulses tick on the last count of each
// DIV-cycle period while enabled, and holds at zero while disabled.
module gravity_timer #(
    parameter int DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: give every always_comb output a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/piece_mover.sv
// Moves the single active piece on the board: spawn, gravity and button
// moves with collision queries, then a lock handshake to the board store.
module piece_mover
    import arcade_defs::*;
#(
    parameter int BOARD_W     = arcade_defs::BOARD_W,
    parameter int BOARD_H     = arcade_defs::BOARD_H,
    parameter int GRAVITY_DIV = 25000000,
    parameter int SPAWN_X     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_drop,
    output logic [X_W-1:0] occ_x,
    output logic [Y_W-1:0] occ_y,
    input  logic           occ_hit,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           piece_active,
    output logic           lock_valid,
    input  logic           lock_ready,
    output logic           game_over
);

    state_e         state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           active_q, active_d;
    logic           tick;

    gravity_timer #(
        .DIV (GRAVITY_DIV)
    ) u_gravity_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == ST_FALL),
        .tick   (tick)
    );

    // Down outranks lateral moves; opposing lateral buttons cancel out.
    logic down_req, left_req, right_req;
    logic at_floor, at_left, at_right;

    assign down_req  = tick | btn_drop;
    assign left_req  = btn_left & ~btn_right;
    assign right_req = btn_right & ~btn_left;
    assign at_floor  = (y_q == Y_W'(BOARD_H - 1));
    assign at_left   = (x_q == '0);
    assign at_right  = (x_q == X_W'(BOARD_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SPAWN;
            x_q      <= '0;
            y_q      <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        active_d = active_q;
        case (state_q)
            ST_SPAWN: begin
                if (occ_hit) begin
                    state_d  = ST_GAMEOVER;
                    active_d = 1'b0;
                end else begin
                    state_d  = ST_FALL;
                    x_d      = X_W'(SPAWN_X);
                    y_d      = '0;
                    active_d = 1'b1;
                end
            end
            ST_FALL: begin
                if (down_req) begin
                    if (at_floor || occ_hit) begin
                        state_d = ST_LOCK;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else if (left_req) begin
                    if (!at_left && !occ_hit) begin
                        x_d = x_q - 1'b1;
                    end
                end else if (right_req) begin
                    if (!at_right && !occ_hit) begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                if (lock_ready) begin
                    state_d  = ST_SPAWN;
                    active_d = 1'b0;
                end
            end
            ST_GAMEOVER: begin
                active_d = 1'b0;
            end
            default: begin
                state_d = ST_SPAWN;
            end
        endcase
    end

    // The query address only steps off the piece when a legal move needs checking.
    always_comb begin
        occ_x      = x_q;
        occ_y      = y_q;
        lock_valid = 1'b0;
        game_over  = 1'b0;
        case (state_q)
            ST_SPAWN: begin
                occ_x = X_W'(SPAWN_X);
                occ_y = '0;
            end
            ST_FALL: begin
                if (down_req) begin
                    if (!at_floor) occ_y = y_q + 1'b1;
                end else if (left_req) begin
                    if (!at_left) occ_x = x_q - 1'b1;
                end else if (right_req) begin
                    if (!at_right) occ_x = x_q + 1'b1;
                end
            end
            ST_LOCK:     lock_valid = 1'b1;
            ST_GAMEOVER: game_over  = 1'b1;
            default: begin
                occ_x = x_q;
            end
        endcase
    end

    assign x_pos        = x_q;
    assign y_pos        = y_q;
    assign piece_active = active_q;

endmodule

// File: tb/tb_piece_mover.sv
// Bench for piece_mover: a board-store model answers occupancy queries and a
// rule-level reference model predicts every output cycle by cycle.
module tb_piece_mover;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int SX = 4;
    localparam int M_SPAWN = 0, M_FALL = 1, M_LOCK = 2, M_OVER = 3;

    logic       clk;
    logic       rst, btn_left, btn_right, btn_drop, lock_ready, occ_hit;
    logic [3:0] occ_x, x_pos;
    logic [4:0] occ_y, y_pos;
    logic       piece_active, lock_valid, game_over;

    logic       s_left, s_right, s_drop, s_ready, s_occ_hit;
    logic [3:0] s_occ_x, s_x;
    logic [4:0] s_occ_y, s_y;
    logic       s_active, s_lock_valid, s_game_over;

    bit board [0:W-1][0:H-1];

    int n_vec, n_err;
    int m_mode, m_x, m_y, m_cnt;
    bit m_active;

    piece_mover #(.GRAVITY_DIV(4)) u_dut (
        .clk (clk), .rst (rst),
        .btn_left (btn_left), .btn_right (btn_right), .btn_drop (btn_drop),
        .occ_x (occ_x), .occ_y (occ_y), .occ_hit (occ_hit),
        .x_pos (x_pos), .y_pos (y_pos), .piece_active (piece_active),
        .lock_valid (lock_valid), .lock_ready (lock_ready), .game_over (game_over)
    );

    piece_mover #(.GRAVITY_DIV(1000)) u_dut_slow (
        .clk (clk), .rst (rst),
        .btn_left (s_left), .btn_right (s_right), .btn_drop (s_drop),
        .occ_x (s_occ_x), .occ_y (s_occ_y), .occ_hit (s_occ_hit),
        .x_pos (s_x), .y_pos (s_y), .piece_active (s_active),
        .lock_valid (s_lock_valid), .lock_ready (s_ready), .game_over (s_game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        occ_hit = 1'b0;
        if (int'(occ_x) < W && int'(occ_y) < H) occ_hit = board[int'(occ_x)][int'(occ_y)];
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clear_board();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                board[x][y] = 1'b0;
    endtask

    // One clock: drive inputs, advance the reference model, let the board
    // store react after the edge, then compare on the falling edge.
    task automatic cycle(input bit d, input bit l, input bit r, input bit rd,
                         input bit rs, input bit clr);
        bit wr;
        int wx, wy;
        bit tk;
        btn_drop = d; btn_left = l; btn_right = r; lock_ready = rd; rst = rs;
        wr = 1'b0; wx = 0; wy = 0;
        if (rs) begin
            m_mode = M_SPAWN; m_x = 0; m_y = 0; m_active = 1'b0; m_cnt = 0;
        end else begin
            case (m_mode)
                M_SPAWN: begin
                    if (board[SX][0]) begin
                        m_mode = M_OVER;
                    end else begin
                        m_mode = M_FALL; m_x = SX; m_y = 0; m_active = 1'b1; m_cnt = 0;
                    end
                end
                M_FALL: begin
                    tk = ((m_cnt % 4) == 3);
                    m_cnt++;
                    if (tk || d) begin
                        if (m_y == H - 1 || board[m_x][m_y + 1]) m_mode = M_LOCK;
                        else m_y++;
                    end else if (l && !r) begin
                        if (m_x > 0 && !board[m_x - 1][m_y]) m_x--;
                    end else if (r && !l) begin
                        if (m_x < W - 1 && !board[m_x + 1][m_y]) m_x++;
                    end
                end
                M_LOCK: begin
                    if (rd) begin
                        wr = 1'b1; wx = m_x; wy = m_y;
                        m_active = 1'b0; m_mode = M_SPAWN;
                    end
                end
                default: m_active = 1'b0;
            endcase
        end
        @(posedge clk);
        #1;
        if (clr) clear_board();
        if (wr) board[wx][wy] = 1'b1;
        @(negedge clk);
        check("x_pos", int'(x_pos), m_x);
        check("y_pos", int'(y_pos), m_y);
        check("piece_active", int'(piece_active), int'(m_active));
        check("lock_valid", int'(lock_valid), int'(m_mode == M_LOCK));
        check("game_over", int'(game_over), int'(m_mode == M_OVER));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        m_mode = M_SPAWN; m_x = 0; m_y = 0; m_cnt = 0; m_active = 1'b0;
        s_left = 1'b0; s_right = 1'b0; s_drop = 1'b0; s_ready = 1'b0; s_occ_hit = 1'b0;
        clear_board();

        // Reset and first spawn on both instances
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        check("rst_x", int'(x_pos), 0);
        check("rst_active", int'(piece_active), 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("spawn_x", int'(x_pos), 4);
        check("spawn_y", int'(y_pos), 0);
        check("spawn_active", int'(piece_active), 1);
        check("spawn_game_over", int'(game_over), 0);
        check("slow_spawn_x", int'(s_x), 4);

        // Lateral moves into the left wall on the slow-gravity instance
        for (int i = 0; i < 5; i++) begin
            s_left = 1'b1;
            cycle(0, 0, 0, 0, 0, 0);
            check("slow_left_x", int'(s_x), (3 - i < 0) ? 0 : 3 - i);
        end
        s_left = 1'b0; s_right = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        check("slow_right_x", int'(s_x), 1);
        check("slow_y", int'(s_y), 0);
        s_right = 1'b0;

        // Button conflicts
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        check("lr_conflict_x", int'(x_pos), 4);
        cycle(1, 1, 0, 0, 0, 0);
        check("drop_left_x", int'(x_pos), 4);
        check("drop_left_y", int'(y_pos), 1);

        // Stack collision below (4,5), then reset in the middle of LOCK
        cycle(0, 0, 0, 0, 1, 1);
        board[4][6] = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0);
        check("stack_y", int'(y_pos), 5);
        check("stack_lock_valid", int'(lock_valid), 1);
        cycle(0, 0, 0, 0, 1, 1);
        check("lockrst_x", int'(x_pos), 0);
        check("lockrst_lock_valid", int'(lock_valid), 0);
        check("lockrst_active", int'(piece_active), 0);

        // Gravity to the floor, held lock request, handshake and respawn
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 76; i++) cycle(0, 0, 0, 0, 0, 0);
        check("floor_y", int'(y_pos), 19);
        check("floor_no_lock_yet", int'(lock_valid), 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
        check("floor_lock_valid", int'(lock_valid), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        check("floor_lock_held", int'(lock_valid), 1);
        check("floor_lock_held_y", int'(y_pos), 19);
        cycle(0, 0, 0, 1, 0, 0);
        check("handshake_active", int'(piece_active), 0);
        check("handshake_lock_valid", int'(lock_valid), 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("respawn_x", int'(x_pos), 4);
        check("respawn_y", int'(y_pos), 0);
        check("respawn_active", int'(piece_active), 1);

        // Blocked spawn cell: sticky game over until reset
        cycle(0, 0, 0, 0, 1, 1);
        board[4][0] = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++)
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, 0);
        check("gameover_sticky", int'(game_over), 1);
        check("gameover_active", int'(piece_active), 0);
        check("gameover_lock_valid", int'(lock_valid), 0);
        cycle(0, 0, 0, 0, 1, 1);
        check("gameover_cleared", int'(game_over), 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("after_gameover_active", int'(piece_active), 1);

        // Randomised play with occasional resets that also clear the board
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            rs = ($urandom_range(0, 399) == 0);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rs, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
